answer_arbiter: RTL and testbench

- Round controller for the multichannel answering machine.
- Arms a question round on host start and locks in the first player to buzz, with fixed-priority tie-break.
- Runs the answer countdown, applies the host's correct/wrong verdict to per-player scores, and feeds the winner's player index and score to the display scanner.
- Sits between debounced player/host buttons and the scan_tube display path.

---
 rtl/answer_arbiter.sv | 165 ++++++++++++++++
 tb/tb_answer_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/answer_arbiter.sv
// Question-round controller for the multichannel answering machine.
// Arms a round on host start, locks in the first eligible buzzer (lowest
// index wins ties), runs the answer countdown, applies the host verdict to
// per-player saturating scores and hands the winner/score to the display.
module answer_arbiter #(
   parameter int TICK_DIV   = 100_000_000,
   parameter int ANSWER_SEC = 10,
   parameter int PTS_RIGHT  = 1,
   parameter int PTS_WRONG  = 1,
   parameter int SCORE_MAX  = 99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] buzz,
   input  logic       correct,
   input  logic       wrong,
   input  logic       clear_scores,
   output logic [1:0] player,
   output logic [7:0] score,
   output logic       disp_load,
   output logic [6:0] remaining,
   output logic [1:0] state_o,
   output logic [3:0] foul
);

   localparam int              TW        = $clog2(TICK_DIV);
   localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [6:0]      ANS_INIT  = 7'(ANSWER_SEC);
   localparam logic [8:0]      MAX9      = 9'(SCORE_MAX);
   localparam logic [7:0]      SCORE_CAP = 8'(SCORE_MAX);
   localparam logic [8:0]      RIGHT9    = 9'(PTS_RIGHT);
   localparam logic [8:0]      WRONG9    = 9'(PTS_WRONG);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMED  = 2'd1,
      S_ANSWER = 2'd2,
      S_RESULT = 2'd3
   } state_t;

   state_t        state;
   logic [7:0]    scores [4];
   logic [3:0]    buzz_q;
   logic [TW-1:0] tick;
   logic          disp_pend;

   logic [3:0] press;
   logic [3:0] eligible;
   logic [1:0] win_idx;
   logic       arm_win;
   logic       verdict_ok;
   logic       final_tick;
   logic       enter_result;
   logic       load_req;
   logic       disp_req;
   logic [7:0] cur_score;
   logic [8:0] up_sum;
   logic [8:0] dn_diff;
   logic [7:0] res_score;

   assign state_o = state;

   // Press detection, eligibility and round-event decode.
   always_comb begin
      press        = buzz & ~buzz_q;
      eligible     = press & ~foul;
      arm_win      = (state == S_ARMED) && (|eligible);
      verdict_ok   = correct ^ wrong;
      final_tick   = (tick == TICK_LAST) && (remaining == 7'd1);
      // A clear in ANSWER takes precedence over verdict and timeout alike;
      // the countdown freezes for that cycle so the timeout is not lost.
      enter_result = (state == S_ANSWER) && !clear_scores && (verdict_ok || final_tick);
      load_req     = arm_win || (clear_scores && ((state == S_ANSWER) || (state == S_RESULT)));
      disp_req     = disp_pend | load_req;
   end

   // Lowest-index eligible press wins a tie.
   always_comb begin
      win_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (eligible[i]) win_idx = 2'(i);
      end
   end

   // Saturating score arithmetic at 9 bits; timeout uses the wrong path.
   always_comb begin
      cur_score = scores[player];
      up_sum    = {1'b0, cur_score} + RIGHT9;
      dn_diff   = {1'b0, cur_score} - WRONG9;
      if (verdict_ok && correct) res_score = (up_sum > MAX9) ? SCORE_CAP : up_sum[7:0];
      else                       res_score = dn_diff[8] ? 8'd0 : dn_diff[7:0];
   end

   // Round FSM, score bank, countdown and display-load sequencing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         for (int i = 0; i < 4; i++) scores[i] <= 8'd0;
         buzz_q    <= 4'd0;
         tick      <= '0;
         player    <= 2'd0;
         score     <= 8'd0;
         disp_load <= 1'b0;
         disp_pend <= 1'b0;
         remaining <= 7'd0;
         foul      <= 4'd0;
      end else begin
         buzz_q <= buzz;
         // A load request that lands on a pulse cycle is deferred one cycle,
         // so disp_load never stays high for two cycles in a row.
         disp_load <= disp_req & ~disp_load;
         disp_pend <= (disp_req & disp_load) | enter_result;

         if (clear_scores) begin
            for (int i = 0; i < 4; i++) scores[i] <= 8'd0;
         end else if (enter_result) begin
            scores[player] <= res_score;
         end

         case (state)
            S_IDLE: begin
               foul <= foul | press;
               if (start) state <= S_ARMED;
            end
            S_ARMED: begin
               if (arm_win) begin
                  state     <= S_ANSWER;
                  player    <= win_idx;
                  score     <= clear_scores ? 8'd0 : scores[win_idx];
                  remaining <= ANS_INIT;
                  tick      <= '0;
               end else if (clear_scores && (&foul)) begin
                  // Everyone fouled: a clear releases the stuck round.
                  foul <= 4'd0;
               end
            end
            S_ANSWER: begin
               if (clear_scores) begin
                  score <= 8'd0;
               end else if (enter_result) begin
                  state     <= S_RESULT;
                  score     <= res_score;
                  remaining <= 7'd0;
                  tick      <= '0;
               end else if (tick == TICK_LAST) begin
                  tick      <= '0;
                  remaining <= remaining - 7'd1;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            S_RESULT: begin
               if (clear_scores) score <= 8'd0;
               if (start) begin
                  state <= S_ARMED;
                  foul  <= 4'd0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_answer_arbiter.sv
// Bench for answer_arbiter: directed rounds with hand-computed expectations,
// then randomized buttons checked every cycle against a behavioural model.
module tb_answer_arbiter;

   localparam int TICK_DIV   = 4;
   localparam int ANSWER_SEC = 3;
   localparam int PTS_RIGHT  = 1;
   localparam int PTS_WRONG  = 1;
   localparam int SCORE_MAX  = 99;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] buzz;
   logic       correct;
   logic       wrong;
   logic       clear_scores;
   logic [1:0] player;
   logic [7:0] score;
   logic       disp_load;
   logic [6:0] remaining;
   logic [1:0] state_o;
   logic [3:0] foul;

   int n_cmp = 0;
   int n_err = 0;
   logic chk_en = 1'b0;

   answer_arbiter #(
      .TICK_DIV(TICK_DIV), .ANSWER_SEC(ANSWER_SEC), .PTS_RIGHT(PTS_RIGHT),
      .PTS_WRONG(PTS_WRONG), .SCORE_MAX(SCORE_MAX)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .buzz(buzz), .correct(correct),
      .wrong(wrong), .clear_scores(clear_scores), .player(player), .score(score),
      .disp_load(disp_load), .remaining(remaining), .state_o(state_o), .foul(foul)
   );

   // Clock / reset
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 armed, 2 answering, 3 result.
   int          m_mode = 0;
   int          m_scores [4] = '{0, 0, 0, 0};
   int          m_player = 0;
   int          m_score = 0;
   logic [3:0]  m_foul = 4'd0;
   logic [3:0]  m_prev = 4'd0;
   int          m_left = 0;      // clock cycles left in the answer window
   int          m_cyc = 0;
   logic        m_disp = 1'b0;
   logic [31:0] exp_q[$];        // cycles at which a display load is owed

   task automatic model_reset();
      m_mode = 0;
      for (int i = 0; i < 4; i++) m_scores[i] = 0;
      m_player = 0; m_score = 0; m_foul = 4'd0; m_prev = 4'd0;
      m_left = 0; m_disp = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_step();
      logic [3:0] pr;
      logic [3:0] el;
      logic       ver;
      int         w;
      int         ns;
      logic       owed;
      m_cyc++;
      pr = buzz & ~m_prev;
      m_prev = buzz;
      ver = (correct != wrong);
      case (m_mode)
         0: begin
            m_foul = m_foul | pr;
            if (start) m_mode = 1;
         end
         1: begin
            el = pr & ~m_foul;
            if (el != 4'd0) begin
               w = 0;
               for (int i = 3; i >= 0; i--) if (el[i]) w = i;
               m_player = w;
               m_score = clear_scores ? 0 : m_scores[w];
               m_left = ANSWER_SEC * TICK_DIV;
               m_mode = 2;
               exp_q.push_back(32'(m_cyc));
            end else if (clear_scores && m_foul == 4'hF) begin
               m_foul = 4'd0;
            end
         end
         2: begin
            if (clear_scores) begin
               m_score = 0;
               exp_q.push_back(32'(m_cyc));
            end else if (ver || m_left == 1) begin
               if (ver && correct) ns = (m_scores[m_player] + PTS_RIGHT > SCORE_MAX) ? SCORE_MAX : m_scores[m_player] + PTS_RIGHT;
               else                ns = (m_scores[m_player] - PTS_WRONG < 0) ? 0 : m_scores[m_player] - PTS_WRONG;
               m_scores[m_player] = ns;
               m_score = ns;
               m_mode = 3;
               exp_q.push_back(32'(m_cyc + 1));
            end else begin
               m_left--;
            end
         end
         default: begin
            if (clear_scores) begin
               m_score = 0;
               exp_q.push_back(32'(m_cyc));
            end
            if (start) begin
               m_mode = 1;
               m_foul = 4'd0;
            end
         end
      endcase
      if (clear_scores) for (int i = 0; i < 4; i++) m_scores[i] = 0;
      // Owed loads merge into one pulse; a pulse never follows a pulse.
      owed = 1'b0;
      foreach (exp_q[i]) if (exp_q[i] <= 32'(m_cyc)) owed = 1'b1;
      if (owed && !m_disp) begin
         m_disp = 1'b1;
         for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i] <= 32'(m_cyc)) exp_q.delete(i);
      end else begin
         m_disp = 1'b0;
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("state_o", int'(state_o), m_mode);
         check("player", int'(player), m_player);
         check("score", int'(score), m_score);
         check("disp_load", int'(disp_load), int'(m_disp));
         check("remaining", int'(remaining), (m_mode == 2) ? (m_left + TICK_DIV - 1) / TICK_DIV : 0);
         check("foul", int'(foul), int'(m_foul));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input logic s, input logic [3:0] b, input logic c,
                       input logic w, input logic cl);
      start = s; buzz = b; correct = c; wrong = w; clear_scores = cl;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      start = 1'b0; buzz = 4'd0; correct = 1'b0; wrong = 1'b0; clear_scores = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic win_round(input logic [3:0] b);
      step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      step(1'b0, b, 1'b0, 1'b0, 1'b0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [3:0] rb;
      logic [3:0] tg;
      rst = 1'b1;
      start = 1'b0; buzz = 4'd0; correct = 1'b0; wrong = 1'b0; clear_scores = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_state", int'(state_o), 0);
      check("rst_score", int'(score), 0);
      check("rst_remaining", int'(remaining), 0);
      check("rst_disp", int'(disp_load), 0);
      rst = 1'b0;
      @(negedge clk);

      // Basic round: player 2 answers correctly.
      win_round(4'b0100);
      check("basic_state", int'(state_o), 2);
      check("basic_player", int'(player), 2);
      check("basic_remaining", int'(remaining), 3);
      check("basic_load", int'(disp_load), 1);
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      check("basic_res_state", int'(state_o), 3);
      check("basic_res_score", int'(score), 1);
      check("basic_res_noload", int'(disp_load), 0);
      idle(1);
      check("basic_res_load", int'(disp_load), 1);
      idle(1);

      // Tie goes to player 1; player 3 holds and must re-press.
      step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'b1010, 1'b0, 1'b0, 1'b0);
      check("tie_player", int'(player), 1);
      step(1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
      step(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0);
      check("hold_armed", int'(state_o), 1);
      step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0);
      check("repress_player", int'(player), 3);
      step(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);

      // Timeout: player 1 (score 1) loses a point.
      win_round(4'b0010);
      idle(4);
      check("timeout_rem2", int'(remaining), 2);
      idle(8);
      check("timeout_state", int'(state_o), 3);
      check("timeout_score", int'(score), 0);

      // Verdict on the final tick wins over the timeout.
      win_round(4'b0010);
      idle(11);
      check("lasttick_rem1", int'(remaining), 1);
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      check("lasttick_state", int'(state_o), 3);
      check("lasttick_score", int'(score), 1);

      // correct+wrong together is ignored.
      win_round(4'b0100);
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      check("both_state", int'(state_o), 2);
      check("both_score", int'(score), 1);
      step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

      // Saturate player 1 at the ceiling.
      for (int r = 0; r < 100; r++) begin
         win_round(4'b0010);
         step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      end
      check("sat_score", int'(score), 99);
      win_round(4'b0010);
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      check("sat_hold", int'(score), 99);

      // clear_scores during ANSWER.
      win_round(4'b0010);
      check("pre_clear_score", int'(score), 99);
      idle(1);
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      check("clear_score", int'(score), 0);
      check("clear_state", int'(state_o), 2);
      check("clear_load", int'(disp_load), 1);

      // Asynchronous reset in ANSWER.
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_state", int'(state_o), 0);
      check("async_player", int'(player), 0);
      check("async_remaining", int'(remaining), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Foul in IDLE excludes player 0 from the round.
      step(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      check("foul_idle", int'(foul), 1);
      step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
      check("foul_armed", int'(foul), 1);
      step(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      check("foul_ignored", int'(state_o), 1);
      step(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0);
      check("foul_winner", int'(player), 3);
      step(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);

      // Everyone fouled: stuck in ARMED until a clear.
      do_reset();
      step(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
      check("allfoul_stuck", int'(state_o), 1);
      step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
      check("allfoul_cleared", int'(foul), 0);
      step(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
      check("allfoul_winner", int'(player), 2);

      // Randomized traffic against the model.
      rb = 4'd0;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 999) == 0) do_reset();
         tg = 4'd0;
         for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) tg[i] = 1'b1;
         rb = rb ^ tg;
         step(($urandom_range(0, 7) == 0), rb, ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 79) == 0));
      end
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
